// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared register-address constants and requester indices.
package regfile_wb_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] reg_ad_t;
  localparam reg_ad_t REG_ZERO = 5'd0;
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requests, register-file write port and hazard lookups.
interface regfile_wb_arbiter_if #(parameter int n = 32);
  import regfile_wb_arbiter_pkg::*;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  reg_ad_t req0_ad, req1_ad, write_ad, read_1, read_2;
  logic [n-1:0] req0_data, req1_data, data;
  logic wr_enable, pend_1, pend_2;
  modport master (
    output req0_valid, req0_ad, req0_data, req1_valid, req1_ad, req1_data, read_1, read_2,
    input req0_ready, req1_ready, wr_enable, write_ad, data, pend_1, pend_2
  );
  modport slave (
    input req0_valid, req0_ad, req0_data, req1_valid, req1_ad, req1_data, read_1, read_2,
    output req0_ready, req1_ready, wr_enable, write_ad, data, pend_1, pend_2
  );
endinterface

// File: rtl/regfile_wb_arbiter_hold.sv
// wb_hold_entry: one-entry writeback holding register with ready and relative-age tracking.
module wb_hold_entry
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int n  = 32,
  parameter int ID = REQ_ALU
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  reg_ad_t      ad_i,
  input  logic [n-1:0] data_i,
  input  logic         grant_i,
  input  logic         other_keep_i,
  input  logic         other_load_i,
  output logic         ready_o,
  output logic         load_o,
  output logic         keep_o,
  output logic         valid_o,
  output reg_ad_t      ad_o,
  output logic [n-1:0] data_o,
  output logic         young_o
);
  logic valid_q, valid_d, young_q, young_d;
  reg_ad_t ad_q, ad_d;
  logic [n-1:0] data_q, data_d;
  assign ready_o = !valid_q | grant_i;
  assign keep_o  = valid_q & !grant_i;
  assign load_o  = valid_i & ready_o & (ad_i != REG_ZERO);
  // Young while the other entry stays held; on a same-edge capture the ALU side is the younger.
  always_comb begin
    valid_d = load_o | keep_o;
    ad_d    = load_o ? ad_i : ad_q;
    data_d  = load_o ? data_i : data_q;
    young_d = load_o ? (other_keep_i | (other_load_i & (ID == REQ_ALU))) : (young_q & other_keep_i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      young_q <= 1'b0;
      ad_q    <= REG_ZERO;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      young_q <= young_d;
      ad_q    <= ad_d;
      data_q  <= data_d;
    end
  end
  assign valid_o = valid_q;
  assign ad_o    = ad_q;
  assign data_o  = data_q;
  assign young_o = young_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin/age arbitration of ALU and memory writebacks onto the register-file write port.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int n = 32
) (
  input logic clk,
  input logic rst,
  regfile_wb_arbiter_if.slave bus
);
  logic v0, v1, y0, y1, g0, g1, k0, k1, l0, l1, ptr_q, ptr_d;
  reg_ad_t a0, a1;
  logic [n-1:0] d0, d1;
  wb_hold_entry #(.n(n), .ID(REQ_ALU)) u_e0 (
    .clk, .rst, .valid_i(bus.req0_valid), .ad_i(bus.req0_ad), .data_i(bus.req0_data),
    .grant_i(g0), .other_keep_i(k1), .other_load_i(l1), .ready_o(bus.req0_ready),
    .load_o(l0), .keep_o(k0), .valid_o(v0), .ad_o(a0), .data_o(d0), .young_o(y0)
  );
  wb_hold_entry #(.n(n), .ID(REQ_MEM)) u_e1 (
    .clk, .rst, .valid_i(bus.req1_valid), .ad_i(bus.req1_ad), .data_i(bus.req1_data),
    .grant_i(g1), .other_keep_i(k0), .other_load_i(l0), .ready_o(bus.req1_ready),
    .load_o(l1), .keep_o(k1), .valid_o(v1), .ad_o(a1), .data_o(d1), .young_o(y1)
  );
  // Same destination: the older entry goes first so the younger value lands last.
  always_comb begin
    g1    = v1 & (!v0 | ((a0 == a1) ? (y0 | !y1) : ptr_q));
    g0    = v0 & !g1;
    ptr_d = g0 ? 1'(REQ_MEM) : g1 ? 1'(REQ_ALU) : ptr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'(REQ_ALU);
    else ptr_q <= ptr_d;
  end
  assign bus.wr_enable = g0 | g1;
  assign bus.write_ad  = g0 ? a0 : g1 ? a1 : REG_ZERO;
  assign bus.data      = g0 ? d0 : g1 ? d1 : '0;
  assign bus.pend_1 = (bus.read_1 != REG_ZERO) & ((v0 & (a0 == bus.read_1)) | (v1 & (a1 == bus.read_1)));
  assign bus.pend_2 = (bus.read_2 != REG_ZERO) & ((v0 & (a0 == bus.read_2)) | (v1 & (a1 == bus.read_2)));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus with a write-port scoreboard and direct flag checks.
module tb_regfile_wb_arbiter;
  typedef struct {logic [4:0] ad; logic [31:0] d;} wr_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  wr_t exp_q[$];
  logic [31:0] rf [32];
  regfile_wb_arbiter_if #(.n(32)) bus ();
  regfile_wb_arbiter #(.n(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] ad, input logic [31:0] d);
    wr_t w;
    w.ad = ad;
    w.d  = d;
    exp_q.push_back(w);
  endtask

  always @(negedge clk) begin
    if (bus.wr_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got ad=%0d data=%h, expected no write at %0t", bus.write_ad, bus.data, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_ad", 32'(bus.write_ad), 32'(e.ad));
        chk("wr_data", bus.data, e.d);
      end
      rf[bus.write_ad] = bus.data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [4:0]  a0 [3];
    logic [31:0] d0 [3];
    logic [4:0]  a1 [3];
    logic [31:0] d1 [3];
    int i0, i1, cyc;
    logic r0, r1;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    bus.req0_valid = 0; bus.req0_ad = 0; bus.req0_data = 0;
    bus.req1_valid = 0; bus.req1_ad = 0; bus.req1_data = 0;
    bus.read_1 = 0; bus.read_2 = 0;
    step(); step();
    chk("rst_we", 32'(bus.wr_enable), 0);
    chk("rst_ad", 32'(bus.write_ad), 0);
    chk("rst_data", bus.data, 0);
    chk("rst_rdy0", 32'(bus.req0_ready), 1);
    chk("rst_rdy1", 32'(bus.req1_ready), 1);
    chk("rst_pend", {30'd0, bus.pend_1, bus.pend_2}, 0);
    rst = 0;
    step();

    // Round-robin with continuous refill, pointer starts at ALU
    a0 = '{5'd3, 5'd10, 5'd11}; d0 = '{32'hA, 32'h100, 32'h101};
    a1 = '{5'd4, 5'd12, 5'd13}; d1 = '{32'hB, 32'h200, 32'h201};
    push(3, 32'hA); push(4, 32'hB); push(10, 32'h100);
    push(12, 32'h200); push(11, 32'h101); push(13, 32'h201);
    i0 = 0; i1 = 0; cyc = 0;
    while ((i0 < 3 || i1 < 3) && cyc < 20) begin
      bus.req0_valid = (i0 < 3);
      bus.req1_valid = (i1 < 3);
      if (i0 < 3) begin bus.req0_ad = a0[i0]; bus.req0_data = d0[i0]; end
      if (i1 < 3) begin bus.req1_ad = a1[i1]; bus.req1_data = d1[i1]; end
      r0 = bus.req0_ready;
      r1 = bus.req1_ready;
      step();
      if (bus.req0_valid && r0) i0++;
      if (bus.req1_valid && r1) i1++;
      cyc++;
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    chk("rr_budget", 32'(cyc < 20), 1);
    step(); step(); step();

    // Single stream back-to-back on the ALU port
    bus.req0_valid = 1; bus.req0_ad = 5; bus.req0_data = 32'h11; push(5, 32'h11);
    step();
    chk("ss_rdy_a", 32'(bus.req0_ready), 1);
    chk("ss_we_a", 32'(bus.wr_enable), 1);
    bus.req0_ad = 6; bus.req0_data = 32'h22; push(6, 32'h22);
    step();
    bus.req0_valid = 0;
    chk("ss_rdy_b", 32'(bus.req0_ready), 1);
    chk("ss_we_b", 32'(bus.wr_enable), 1);
    step();
    chk("ss_idle", 32'(bus.wr_enable), 0);
    step();

    // Same destination on the same edge: memory is older
    bus.req0_valid = 1; bus.req0_ad = 7; bus.req0_data = 32'h2;
    bus.req1_valid = 1; bus.req1_ad = 7; bus.req1_data = 32'h1;
    push(7, 32'h1); push(7, 32'h2);
    step();
    bus.req0_valid = 0; bus.req1_valid = 0;
    step(); step(); step();
    chk("rf_x7", rf[7], 32'h2);

    // Lone memory write returns the pointer to ALU, then memory x9 loses
    bus.req1_valid = 1; bus.req1_ad = 1; bus.req1_data = 32'h55; push(1, 32'h55);
    step();
    bus.req1_valid = 0;
    step(); step();
    bus.read_2 = 9;
    bus.req0_valid = 1; bus.req0_ad = 8; bus.req0_data = 32'h80;
    bus.req1_valid = 1; bus.req1_ad = 9; bus.req1_data = 32'h90;
    push(8, 32'h80); push(9, 32'h90);
    chk("hz_pre", 32'(bus.pend_2), 0);
    step();
    bus.req0_valid = 0; bus.req1_valid = 0;
    chk("hz_held", 32'(bus.pend_2), 1);
    chk("bp_rdy1", 32'(bus.req1_ready), 0);
    chk("bp_ad", 32'(bus.write_ad), 8);
    step();
    chk("hz_wcyc", 32'(bus.pend_2), 1);
    chk("bp_rdy1_g", 32'(bus.req1_ready), 1);
    step();
    chk("hz_done", 32'(bus.pend_2), 0);
    bus.read_2 = 0;
    step();

    // x0 write is accepted and discarded
    bus.read_1 = 0;
    bus.req0_valid = 1; bus.req0_ad = 0; bus.req0_data = 32'hFFFF_FFFF;
    chk("x0_rdy", 32'(bus.req0_ready), 1);
    step();
    bus.req0_valid = 0;
    chk("x0_we", 32'(bus.wr_enable), 0);
    chk("x0_pend", 32'(bus.pend_1), 0);
    step();
    chk("x0_we2", 32'(bus.wr_enable), 0);

    // Reset mid-cycle with both entries held
    bus.read_1 = 20; bus.read_2 = 21;
    bus.req0_valid = 1; bus.req0_ad = 20; bus.req0_data = 32'hC0;
    bus.req1_valid = 1; bus.req1_ad = 21; bus.req1_data = 32'hC1;
    step();
    bus.req0_valid = 0; bus.req1_valid = 0;
    chk("mr_pend1", 32'(bus.pend_1), 1);
    chk("mr_pend2", 32'(bus.pend_2), 1);
    #1 rst = 1;
    #1;
    chk("mr_we", 32'(bus.wr_enable), 0);
    chk("mr_rdy", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd3);
    chk("mr_pend", {30'd0, bus.pend_1, bus.pend_2}, 0);
    step(); step();
    rst = 0;
    step(); step();
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
